// File: rtl/instr_fetch.sv
// instr_fetch: program counter, instruction memory and branch-target LUT feeding the decoder.
module instr_fetch #(
    parameter int             IW        = 9,
    parameter int             PW        = 10,
    parameter int             LW        = 5,
    parameter logic [IW-1:0]  HALT_WORD = 9'h1FF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          Branch,
    input  logic          Taken,
    input  logic [LW-1:0] TargetIdx,
    input  logic          ImWrEn,
    input  logic [PW-1:0] ImWrAddr,
    input  logic [IW-1:0] ImWrData,
    input  logic          LutWrEn,
    input  logic [LW-1:0] LutWrAddr,
    input  logic [PW-1:0] LutWrData,
    output logic [IW-1:0] Instr,
    output logic [PW-1:0] PC,
    output logic          InstrValid,
    output logic          Done
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pc_q, pc_d, fa;
    logic [IW-1:0] instr_q;
    logic          valid_q, valid_d, done_q, done_d, load, idle_like;
    logic [IW-1:0] imem_q [2**PW];
    logic [PW-1:0] lut_q [2**LW];

    always_comb begin
        idle_like = state_q != S_FETCH;
        load      = 1'b0;
        fa        = (Branch && Taken) ? lut_q[TargetIdx] : pc_q + PW'(1);
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        done_d    = done_q;
        if (idle_like && Start) begin
            load = 1'b1;
            fa   = '0;
        end else if (state_q == S_FETCH && !Stall) begin
            if (instr_q == HALT_WORD) begin
                state_d = S_HALT;
                valid_d = 1'b0;
                done_d  = 1'b1;
            end else begin
                load = 1'b1;
            end
        end
        if (load) begin
            state_d = S_FETCH;
            pc_d    = fa;
            valid_d = 1'b1;
            done_d  = 1'b0;
        end
    end

    // Writes only outside FETCH; the Start fetch sees pre-write contents via NBA ordering.
    always_ff @(posedge Clk) begin
        if (idle_like && ImWrEn) imem_q[ImWrAddr] <= ImWrData;
        if (idle_like && LutWrEn) lut_q[LutWrAddr] <= LutWrData;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            if (load) instr_q <= imem_q[fa];
        end
    end

    assign Instr      = instr_q;
    assign PC         = pc_q;
    assign InstrValid = valid_q;
    assign Done       = done_q;
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit that produces the 9-bit machine-code word consumed by the control decoder.
- Owns the program counter, the instruction memory and the branch-target lookup table.
- Advances the PC sequentially, or redirects it through the LUT when the decoder signals a taken branch.
- Detects the halt word and raises Done.

Parameters:
IW, 9, instruction width (matches the decoder's machine-code width)
PW, 10, PC width; instruction memory depth is 2**PW
LW, 5, branch-target LUT index width; LUT depth is 2**LW
HALT_WORD, 9'h1FF, instruction encoding that stops fetch

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  begin (or restart) execution at PC 0
Stall  in  1  hold PC, Instr and state this cycle
Branch  in  1  from control decoder: presented Instr is a branch
Taken  in  1  branch condition result (ALU flag) for the presented Instr
TargetIdx  in  LW  LUT index selecting the branch target
ImWrEn  in  1  instruction memory write enable (program load)
ImWrAddr  in  PW  instruction memory write address
ImWrData  in  IW  instruction memory write data
LutWrEn  in  1  LUT write enable
LutWrAddr  in  LW  LUT write address
LutWrData  in  PW  LUT write data (absolute target PC)
Instr  out  IW  registered instruction presented to the decoder
PC  out  PW  address of the presented Instr
InstrValid  out  1  Instr/PC are a live instruction
Done  out  1  halt word retired; sticky until Start or Reset

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high; on a Clk edge with Reset=1:
  - state=IDLE, PC=0, Instr=0, InstrValid=0, Done=0.
  - Memory and LUT contents are not cleared.
  - Reset takes priority over every other input, including mid-FETCH; in-flight instruction is discarded.
- States:
  - IDLE: InstrValid=0. Start=1 -> Instr<=imem[0], PC<=0, InstrValid<=1, Done<=0, go FETCH. Stall is ignored in IDLE.
  - FETCH: the presented Instr is live.
    - If Stall=1: all registers hold.
    - Else if Instr==HALT_WORD: InstrValid<=0, Done<=1, go HALT. PC/Instr hold the halt word.
    - Else advance:
      - fa = (Branch & Taken) ? lut[TargetIdx] : PC+1.
      - PC+1 wraps modulo 2**PW (PC 1023 -> 0).
      - Instr<=imem[fa], PC<=fa.
    - Start is ignored in FETCH.
  - HALT: outputs hold, Done=1. Start=1 behaves exactly as from IDLE (restart at 0, Done<=0).
- Latency: a taken branch costs no bubble. The target instruction is presented the cycle after the branch is presented (one instruction per unstalled cycle).
- Branch=1 with Taken=0 falls through to PC+1. Taken is ignored when Branch=0.
- Halt takes priority over Branch when the presented word is HALT_WORD.
- Writes:
  - ImWrEn and LutWrEn are honoured only in IDLE and HALT; ignored in FETCH.
  - Written data is readable on the next cycle.
  - A write in the same cycle as Start takes effect, but the Start fetch reads the pre-write contents of address 0.
- Memory: imem read is synchronous into the Instr register; no combinational path from the memory to Instr.
- Done and InstrValid are never both 1.

Test Plan:
- Reset/start: load imem[0..2]={9'h001,9'h002,9'h1FF}, pulse Start -> Instr 001/002/1FF with PC 0/1/2 on consecutive cycles; then InstrValid=0, Done=1 from the fourth cycle.
- Taken branch: lut[3]=10'd40, imem[1] presented with Branch=1, Taken=1, TargetIdx=3 -> next cycle PC=40, Instr=imem[40], no bubble. Same with Taken=0 -> PC=2.
- Stall: assert Stall for 3 cycles at PC=5 -> PC=5 and Instr unchanged for 3 cycles, PC=6 on the cycle after Stall drops. Branch inputs asserted during the stall have no effect.
- Wrap: lut[0]=10'd1023, branch there; imem[1023]=9'h005 -> next PC=0, Instr=imem[0].
- Writes gated: ImWrEn to address 7 during FETCH -> imem[7] unchanged. After HALT, same write lands; Start then reruns from PC 0 with Done cleared on the first FETCH cycle.
- Reset mid-run: Reset=1 at PC=12 in FETCH -> next cycle PC=0, Instr=0, InstrValid=0, Done=0, state IDLE. imem and LUT contents are preserved.
